// File: rtl/drive_cmd_arbiter_pkg.sv
// Shared encodings for the drive command arbiter:
// mode codes, command bit positions and FSM state codes.
package drive_cmd_arbiter_pkg;

  typedef logic [3:0] cmd_t;

  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_MAN  = 2'b01;
  localparam logic [1:0] MODE_SEMI = 2'b10;
  localparam logic [1:0] MODE_AUTO = 2'b11;

  localparam int BACK  = 3;
  localparam int FWD   = 2;
  localparam int LEFT  = 1;
  localparam int RIGHT = 0;

  localparam logic [1:0] ST_OFF = 2'd0;
  localparam logic [1:0] ST_GAP = 2'd1;
  localparam logic [1:0] ST_RUN = 2'd2;

  // Opposing motion pairs cancel rather than pick a winner.
  function automatic cmd_t mask_cmd(input cmd_t c);
    cmd_t r;
    r = c;
    if (c[BACK] && c[FWD]) begin
      r[BACK] = 1'b0;
      r[FWD]  = 1'b0;
    end
    if (c[LEFT] && c[RIGHT]) begin
      r[LEFT]  = 1'b0;
      r[RIGHT] = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/drive_cmd_arbiter_pulser.sv
// Barrier place/destroy pulse generator with a
// bounded beacon budget and a reject strobe.
module barrier_pulser
  import drive_cmd_arbiter_pkg::*;
#(
  parameter int PULSE_TICKS = 5,
  parameter int MAX_BEACONS = 4,
  parameter int CW = $clog2(MAX_BEACONS + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tick,
  input  logic          enable,
  input  logic          place_req,
  input  logic          destroy_req,
  output logic          place_pulse,
  output logic          destroy_pulse,
  output logic [CW-1:0] count,
  output logic          reject
);

  localparam int PW = $clog2(PULSE_TICKS + 1);

  logic          place_prev;
  logic          destroy_prev;
  logic [PW-1:0] pulse_cnt;
  logic          busy;
  logic          place_edge;
  logic          destroy_edge;

  assign busy         = place_pulse | destroy_pulse;
  assign place_edge   = place_req & ~place_prev;
  assign destroy_edge = destroy_req & ~destroy_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      place_prev    <= 1'b0;
      destroy_prev  <= 1'b0;
      pulse_cnt     <= '0;
      place_pulse   <= 1'b0;
      destroy_pulse <= 1'b0;
      count         <= '0;
      reject        <= 1'b0;
    end else if (!enable) begin
      // Track levels while idle so a level held at RUN entry is not an edge.
      place_prev    <= place_req;
      destroy_prev  <= destroy_req;
      pulse_cnt     <= '0;
      place_pulse   <= 1'b0;
      destroy_pulse <= 1'b0;
      reject        <= 1'b0;
    end else if (tick) begin
      place_prev   <= place_req;
      destroy_prev <= destroy_req;
      reject       <= 1'b0;
      if (busy) begin
        if (pulse_cnt == '0) begin
          place_pulse   <= 1'b0;
          destroy_pulse <= 1'b0;
        end else begin
          pulse_cnt <= pulse_cnt - PW'(1);
        end
      end else if (destroy_edge) begin
        destroy_pulse <= 1'b1;
        pulse_cnt     <= PW'(PULSE_TICKS - 1);
        if (count != '0) count <= count - CW'(1);
      end else if (place_edge) begin
        if (count < CW'(MAX_BEACONS)) begin
          place_pulse <= 1'b1;
          pulse_cnt   <= PW'(PULSE_TICKS - 1);
          count       <= count + CW'(1);
        end else begin
          reject <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/drive_cmd_arbiter.sv
// Selects one driving engine per mode, inserts a braked
// changeover gap and drives barrier pulses.
module drive_cmd_arbiter
  import drive_cmd_arbiter_pkg::*;
#(
  parameter int TICK_DIV    = 1_000_000,
  parameter int SWITCH_GAP  = 20,
  parameter int PULSE_TICKS = 5,
  parameter int MAX_BEACONS = 4,
  parameter int CW = $clog2(MAX_BEACONS + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          power_on,
  input  logic [1:0]    mode_sel,
  input  logic [3:0]    man_cmd,
  input  logic [3:0]    semi_cmd,
  input  logic [3:0]    auto_cmd,
  input  logic          man_place_req,
  input  logic          man_destroy_req,
  input  logic          auto_place_req,
  input  logic          auto_destroy_req,
  output logic          move_backward,
  output logic          move_forward,
  output logic          turn_left,
  output logic          turn_right,
  output logic          place_barrier_signal,
  output logic          destroy_barrier_signal,
  output logic [1:0]    active_mode,
  output logic          switching,
  output logic [CW-1:0] beacon_count,
  output logic          beacon_reject
);

  localparam int TW = $clog2(TICK_DIV + 1);
  localparam int GW = $clog2(SWITCH_GAP + 1);

  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [1:0]    mode_prev;
  logic [GW-1:0] gap_cnt;
  logic          run_stay;
  logic          gap_done;
  cmd_t          sel_cmd;
  logic          place_req;
  logic          destroy_req;

  assign tick = (tick_cnt == TW'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else tick_cnt <= tick_cnt + TW'(1);
  end

  assign gap_done = tick && (mode_sel == mode_prev)
                 && (gap_cnt == GW'(SWITCH_GAP - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      ST_OFF:
        if (mode_sel != MODE_OFF) state_nxt = ST_GAP;
      ST_GAP:
        if (gap_done)
          state_nxt = (mode_sel == MODE_OFF) ? ST_OFF : ST_RUN;
      ST_RUN:
        if (mode_sel == MODE_OFF) state_nxt = ST_OFF;
        else if (mode_sel != active_mode) state_nxt = ST_GAP;
      default: state_nxt = ST_OFF;
    endcase
    if (!power_on) state_nxt = ST_OFF;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_OFF;
      mode_prev   <= MODE_OFF;
      gap_cnt     <= '0;
      active_mode <= MODE_OFF;
    end else begin
      state     <= state_nxt;
      mode_prev <= mode_sel;
      if (state_nxt == ST_GAP &&
          (state != ST_GAP || mode_sel != mode_prev))
        gap_cnt <= '0;
      else if (state == ST_GAP && tick)
        gap_cnt <= gap_cnt + GW'(1);
      if (state_nxt == ST_RUN && state != ST_RUN)
        active_mode <= mode_sel;
      else if (state_nxt != ST_RUN)
        active_mode <= MODE_OFF;
    end
  end

  assign switching = (state == ST_GAP);
  assign run_stay  = (state == ST_RUN) && (state_nxt == ST_RUN);

  always_comb begin
    sel_cmd = '0;
    case (active_mode)
      MODE_MAN:  sel_cmd = man_cmd;
      MODE_SEMI: sel_cmd = semi_cmd;
      MODE_AUTO: sel_cmd = auto_cmd;
      default:   sel_cmd = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      {move_backward, move_forward, turn_left, turn_right} <= 4'b0;
    end else if (run_stay) begin
      {move_backward, move_forward, turn_left, turn_right}
        <= mask_cmd(sel_cmd);
    end else begin
      {move_backward, move_forward, turn_left, turn_right} <= 4'b0;
    end
  end

  // Steered by mode_sel so edge history follows the incoming source during GAP.
  assign place_req   = (mode_sel == MODE_AUTO) ? auto_place_req
                                               : man_place_req;
  assign destroy_req = (mode_sel == MODE_AUTO) ? auto_destroy_req
                                               : man_destroy_req;

  barrier_pulser #(
    .PULSE_TICKS (PULSE_TICKS),
    .MAX_BEACONS (MAX_BEACONS),
    .CW          (CW)
  ) u_pulser (
    .clk           (clk),
    .reset         (reset),
    .tick          (tick),
    .enable        (run_stay),
    .place_req     (place_req),
    .destroy_req   (destroy_req),
    .place_pulse   (place_barrier_signal),
    .destroy_pulse (destroy_barrier_signal),
    .count         (beacon_count),
    .reject        (beacon_reject)
  );

endmodule

// File: tb/tb_drive_cmd_arbiter.sv
// Self-checking bench for drive_cmd_arbiter with small
// tick/gap/pulse parameters.
module tb_drive_cmd_arbiter;

  localparam int TD = 4;
  localparam int SG = 3;
  localparam int PT = 2;
  localparam int MB = 2;
  localparam int CW = $clog2(MB + 1);

  logic          clk;
  logic          reset;
  logic          power_on;
  logic [1:0]    mode_sel;
  logic [3:0]    man_cmd;
  logic [3:0]    semi_cmd;
  logic [3:0]    auto_cmd;
  logic          man_place_req;
  logic          man_destroy_req;
  logic          auto_place_req;
  logic          auto_destroy_req;
  logic          move_backward;
  logic          move_forward;
  logic          turn_left;
  logic          turn_right;
  logic          place_barrier_signal;
  logic          destroy_barrier_signal;
  logic [1:0]    active_mode;
  logic          switching;
  logic [CW-1:0] beacon_count;
  logic          beacon_reject;

  drive_cmd_arbiter #(
    .TICK_DIV    (TD),
    .SWITCH_GAP  (SG),
    .PULSE_TICKS (PT),
    .MAX_BEACONS (MB)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .power_on               (power_on),
    .mode_sel               (mode_sel),
    .man_cmd                (man_cmd),
    .semi_cmd               (semi_cmd),
    .auto_cmd               (auto_cmd),
    .man_place_req          (man_place_req),
    .man_destroy_req        (man_destroy_req),
    .auto_place_req         (auto_place_req),
    .auto_destroy_req       (auto_destroy_req),
    .move_backward          (move_backward),
    .move_forward           (move_forward),
    .turn_left              (turn_left),
    .turn_right             (turn_right),
    .place_barrier_signal   (place_barrier_signal),
    .destroy_barrier_signal (destroy_barrier_signal),
    .active_mode            (active_mode),
    .switching              (switching),
    .beacon_count           (beacon_count),
    .beacon_reject          (beacon_reject)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running tick phase, restarted by reset.
  int bcnt;
  always @(posedge clk or posedge reset) begin
    if (reset) bcnt <= 0;
    else if (bcnt == TD - 1) bcnt <= 0;
    else bcnt <= bcnt + 1;
  end

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] cmd;
    logic [3:0] exp;
  } vec_t;

  vec_t       vecs[8];
  logic [3:0] sb[$];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] mot();
    return {move_backward, move_forward, turn_left, turn_right};
  endfunction

  // Advance to just after the next clk edge on which tick is high.
  task automatic next_tick();
    while (bcnt != TD - 1) begin
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic go_mode(input logic [1:0] m);
    mode_sel = m;
    @(posedge clk);
    #1;
    repeat (SG) next_tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{4'b1111, 4'b0000};
    vecs[1] = '{4'b0110, 4'b0110};
    vecs[2] = '{4'b1100, 4'b0000};
    vecs[3] = '{4'b0011, 4'b0000};
    vecs[4] = '{4'b1001, 4'b1001};
    vecs[5] = '{4'b1110, 4'b0010};
    vecs[6] = '{4'b0101, 4'b0101};
    vecs[7] = '{4'b0000, 4'b0000};

    reset = 1'b1;
    power_on = 1'b0;
    mode_sel = 2'b00;
    man_cmd = 4'b0;
    semi_cmd = 4'b0;
    auto_cmd = 4'b0;
    man_place_req = 1'b0;
    man_destroy_req = 1'b0;
    auto_place_req = 1'b0;
    auto_destroy_req = 1'b0;
    #22;
    reset = 1'b0;
    @(posedge clk);
    #1;

    chk("rst_motion", mot(), 4'b0);
    chk("rst_place", place_barrier_signal, 0);
    chk("rst_destroy", destroy_barrier_signal, 0);
    chk("rst_active", active_mode, 0);
    chk("rst_switching", switching, 0);
    chk("rst_count", beacon_count, 0);
    chk("rst_reject", beacon_reject, 0);

    // Power up into manual
    power_on = 1'b1;
    mode_sel = 2'b01;
    man_cmd = 4'b0100;
    semi_cmd = 4'b0001;
    auto_cmd = 4'b1000;
    @(posedge clk);
    #1;
    chk("gap_enter", switching, 1);
    chk("gap_active", active_mode, 0);
    next_tick();
    next_tick();
    chk("gap_hold", switching, 1);
    chk("gap_motion", mot(), 4'b0);
    next_tick();
    chk("run_switching", switching, 0);
    chk("run_active", active_mode, 2'b01);
    chk("run_entry_motion", mot(), 4'b0);
    @(posedge clk);
    #1;
    chk("run_fwd", mot(), 4'b0100);

    // Mode change with restart of the gap
    mode_sel = 2'b11;
    @(posedge clk);
    #1;
    chk("chg_switching", switching, 1);
    chk("chg_motion", mot(), 4'b0);
    chk("chg_active", active_mode, 0);
    next_tick();
    mode_sel = 2'b10;
    @(posedge clk);
    #1;
    chk("restart_switching", switching, 1);
    next_tick();
    next_tick();
    chk("restart_hold", switching, 1);
    chk("restart_motion", mot(), 4'b0);
    next_tick();
    chk("semi_active", active_mode, 2'b10);
    chk("semi_switching", switching, 0);
    @(posedge clk);
    #1;
    chk("semi_motion", mot(), 4'b0001);

    // Conflict masking table in manual mode
    go_mode(2'b01);
    chk("man_active", active_mode, 2'b01);
    for (int i = 0; i < 8; i++) begin
      man_cmd = vecs[i].cmd;
      sb.push_back(vecs[i].exp);
      @(posedge clk);
      #1;
      chk($sformatf("mask_vec%0d", i), mot(), sb.pop_front());
    end

    // Place budget and reject
    man_place_req = 1'b1;
    next_tick();
    chk("p1_pulse", place_barrier_signal, 1);
    chk("p1_count", beacon_count, 1);
    next_tick();
    chk("p1_hold", place_barrier_signal, 1);
    man_place_req = 1'b0;
    next_tick();
    chk("p1_end", place_barrier_signal, 0);
    next_tick();
    man_place_req = 1'b1;
    next_tick();
    chk("p2_pulse", place_barrier_signal, 1);
    chk("p2_count", beacon_count, 2);
    next_tick();
    chk("p2_hold", place_barrier_signal, 1);
    man_place_req = 1'b0;
    next_tick();
    chk("p2_end", place_barrier_signal, 0);
    next_tick();
    man_place_req = 1'b1;
    next_tick();
    chk("p3_reject", beacon_reject, 1);
    chk("p3_nopulse", place_barrier_signal, 0);
    chk("p3_count", beacon_count, 2);
    next_tick();
    chk("p3_reject_end", beacon_reject, 0);
    man_place_req = 1'b0;
    man_destroy_req = 1'b1;
    next_tick();
    chk("d1_pulse", destroy_barrier_signal, 1);
    chk("d1_count", beacon_count, 1);
    next_tick();
    man_destroy_req = 1'b0;
    next_tick();
    chk("d1_end", destroy_barrier_signal, 0);
    next_tick();

    // Drain to zero, then simultaneous edges
    man_destroy_req = 1'b1;
    next_tick();
    chk("d2_count", beacon_count, 0);
    next_tick();
    man_destroy_req = 1'b0;
    next_tick();
    next_tick();
    man_place_req = 1'b1;
    man_destroy_req = 1'b1;
    next_tick();
    chk("both_destroy", destroy_barrier_signal, 1);
    chk("both_noplace", place_barrier_signal, 0);
    chk("both_count", beacon_count, 0);
    man_place_req = 1'b0;
    man_destroy_req = 1'b0;
    next_tick();
    man_place_req = 1'b1;
    next_tick();
    chk("busy_edge_place", place_barrier_signal, 0);
    chk("busy_destroy_end", destroy_barrier_signal, 0);
    next_tick();
    chk("busy_not_queued", place_barrier_signal, 0);
    chk("busy_count", beacon_count, 0);
    man_place_req = 1'b0;

    // Power-off mid pulse
    man_cmd = 4'b0100;
    next_tick();
    man_place_req = 1'b1;
    next_tick();
    chk("po_pulse", place_barrier_signal, 1);
    chk("po_motion_pre", mot(), 4'b0100);
    power_on = 1'b0;
    @(posedge clk);
    #1;
    chk("po_place", place_barrier_signal, 0);
    chk("po_motion", mot(), 4'b0);
    chk("po_active", active_mode, 0);
    chk("po_switching", switching, 0);
    chk("po_count", beacon_count, 1);
    man_place_req = 1'b0;
    power_on = 1'b1;
    go_mode(2'b01);
    chk("pon_active", active_mode, 2'b01);
    chk("pon_count", beacon_count, 1);

    // Asynchronous reset mid pulse
    next_tick();
    man_place_req = 1'b1;
    next_tick();
    chk("rp_pulse", place_barrier_signal, 1);
    chk("rp_count", beacon_count, 2);
    #3;
    reset = 1'b1;
    #1;
    chk("ar_place", place_barrier_signal, 0);
    chk("ar_motion", mot(), 4'b0);
    chk("ar_count", beacon_count, 0);
    chk("ar_active", active_mode, 0);
    #2;
    reset = 1'b0;
    man_place_req = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_switching", switching, 1);
    chk("post_rst_motion", mot(), 4'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
